serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 87 ++++++++
 tb/tb_serial_add_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: N-bit adder that reuses one full-adder slice, one bit per clock, LSB first.
// Ports: clk, rst (sync, active-high); start/a/b/cin captured in IDLE;
//        busy high during RUN, done pulses in FIN; sum/cout hold the last completed result.
module ha_str (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module fa_str (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s1, c1, c2;
  ha_str h0 (.x(x),  .y(y),  .s(s1), .c(c1));
  ha_str h1 (.x(s1), .y(ci), .s(s),  .c(c2));
  assign co = c1 | c2;
endmodule

module serial_add_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_n;
  logic [N-1:0] ra, rb, sreg, sreg_n;
  logic [CW-1:0] cnt;
  logic carry, s, c, last;
  fa_str slice (.x(ra[0]), .y(rb[0]), .ci(carry), .s(s), .co(c));
  assign last = (cnt == CW'(N - 1));
  always_comb begin
    sreg_n = sreg >> 1;
    sreg_n[N-1] = s;
    state_n = (state == IDLE) ? (start ? RUN : IDLE) :
              (state == RUN)  ? (last ? FIN : RUN)   : IDLE;
    busy = (state == RUN);
    done = (state == FIN);
  end
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ra    <= '0;
      rb    <= '0;
      sreg  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (state == IDLE && start) begin
      ra    <= a;
      rb    <= b;
      carry <= cin;
      sreg  <= '0;
      cnt   <= '0;
    end else if (state == RUN) begin
      ra    <= ra >> 1;
      rb    <= rb >> 1;
      sreg  <= sreg_n;
      carry <= c;
      cnt   <= cnt + 1'b1;
      if (last) begin
        sum  <= sreg_n;
        cout <= c;
      end
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: table vectors, corner sequences and random ops for N=8 and N=1 instances.
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic       start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       start1 = 1'b0, cin1 = 1'b0, busy1, done1, cout1;
  logic [0:0] a1 = '0, b1 = '0, sum1;
  int checks = 0, failures = 0;

  serial_add_ctrl #(.N(8)) u8 (.clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
                               .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));
  serial_add_ctrl #(.N(1)) u1 (.clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
                               .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // start pulsed in cycle 0; busy in cycles 1..8, done only in cycle 9
  task automatic op8(input string nm, input logic [7:0] a, input logic [7:0] b, input logic ci,
                     input logic [7:0] es, input logic eco);
    a8 = a; b8 = b; cin8 = ci; start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk({nm, " busy"}, 32'(busy8), 32'd1);
      chk({nm, " done early"}, 32'(done8), 32'd0);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      step();
    end
    chk({nm, " done"}, 32'(done8), 32'd1);
    chk({nm, " busy in fin"}, 32'(busy8), 32'd0);
    chk({nm, " sum"}, 32'(sum8), 32'(es));
    chk({nm, " cout"}, 32'(cout8), 32'(eco));
    step();
    chk({nm, " done one cycle"}, 32'(done8), 32'd0);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rc, qa, qb, qc;
    logic [8:0] exp8;
    logic [1:0] exp1;
    int d8, d1;
    tbl[0] = '{8'h3C, 8'h55, 1'b0, 8'h91, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tbl[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
    tbl[6] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
    tbl[7] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

    step();
    step();
    chk("reset busy", 32'(busy8), 32'd0);
    chk("reset done", 32'(done8), 32'd0);
    chk("reset sum", 32'(sum8), 32'd0);
    chk("reset cout", 32'(cout8), 32'd0);
    chk("reset n1 busy", 32'(busy1), 32'd0);
    chk("reset n1 sum", 32'({cout1, sum1}), 32'd0);
    rst = 1'b0;
    step();

    foreach (tbl[i]) op8($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].co);

    // start while busy is ignored and operands are not re-sampled
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step();
    step();
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
    step();
    start8 = 1'b0;
    for (int k = 4; k <= 8; k++) begin
      chk("busy start done early", 32'(done8), 32'd0);
      step();
    end
    chk("busy start done", 32'(done8), 32'd1);
    chk("busy start sum", 32'(sum8), 32'h30);
    chk("busy start cout", 32'(cout8), 32'd0);
    for (int k = 10; k <= 16; k++) begin
      step();
      chk("busy start no second op", 32'({busy8, done8}), 32'd0);
    end

    // reset mid-RUN aborts and clears the result
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst busy", 32'(busy8), 32'd0);
    chk("midrst sum", 32'(sum8), 32'd0);
    chk("midrst cout", 32'(cout8), 32'd0);
    for (int k = 0; k < 12; k++) begin
      chk("midrst no done", 32'({busy8, done8}), 32'd0);
      step();
    end
    op8("after rst", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);

    // reset and start on the same edge: request lost
    a8 = 8'h01; b8 = 8'h01; start8 = 1'b1; start1 = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; start8 = 1'b0; start1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("rst+start n8", 32'({busy8, done8}), 32'd0);
      chk("rst+start n1", 32'({busy1, done1}), 32'd0);
      step();
    end

    // N=1 with start held: done every 3 cycles
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
    step();
    for (int k = 1; k <= 12; k++) begin
      chk("n1 cont busy", 32'(busy1), 32'(k % 3 == 1));
      chk("n1 cont done", 32'(done1), 32'(k % 3 == 2));
      if (k % 3 == 2) chk("n1 cont result", 32'({cout1, sum1}), 32'd3);
      step();
    end
    start1 = 1'b0;
    step();
    step();
    step();

    // random operations on both widths against plain arithmetic
    for (int op = 0; op < 500; op++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      qa = 1'($urandom); qb = 1'($urandom); qc = 1'($urandom);
      exp8 = 9'(ra) + 9'(rb) + 9'(rc);
      exp1 = 2'(qa) + 2'(qb) + 2'(qc);
      a8 = ra; b8 = rb; cin8 = rc; a1 = qa; b1 = qb; cin1 = qc;
      start8 = 1'b1; start1 = 1'b1;
      step();
      start8 = 1'b0; start1 = 1'b0;
      d8 = -1; d1 = -1;
      for (int c = 1; c <= 14; c++) begin
        if (done8 && d8 < 0) begin
          d8 = c;
          chk("rnd n8 result", 32'({cout8, sum8}), 32'(exp8));
        end
        if (done1 && d1 < 0) begin
          d1 = c;
          chk("rnd n1 result", 32'({cout1, sum1}), 32'(exp1));
        end
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
        if (d8 >= 0 && d1 >= 0) break;
        step();
      end
      chk("rnd n8 latency", 32'(d8), 32'd9);
      chk("rnd n1 latency", 32'(d1), 32'd2);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
